// File: rtl/debounce.sv
// debounce: synchronizes a raw, possibly bouncing level and accepts a new level only
// after STABLE_CYCLES consecutive agreeing synchronized samples.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   in   - raw asynchronous input level
//   o    - debounced level (registered)
//   rise - one-cycle pulse on an accepted 0->1 transition of o (registered)
//   fall - one-cycle pulse on an accepted 1->0 transition of o (registered)
module debounce #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic o,
   output logic rise,
   output logic fall
);
   typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} state_t;
   localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);
   state_t state, state_n;
   logic [7:0] cnt, cnt_n;
   logic sync_d, sync_q, done, o_n, rise_n, fall_n;
   assign done = cnt == LAST;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync_d <= 1'b0;
         sync_q <= 1'b0;
         state  <= LOW;
         cnt    <= 8'd0;
         o      <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_d <= in;
         sync_q <= sync_d;
         state  <= state_n;
         cnt    <= cnt_n;
         o      <= o_n;
         rise   <= rise_n;
         fall   <= fall_n;
      end
   // cnt holds the number of agreeing samples seen so far in a WAIT state;
   // it is zero in every other state and never exceeds LAST.
   always_comb begin
      state_n = state;
      cnt_n   = 8'd0;
      case (state)
         LOW:     if (sync_q) begin state_n = WAIT_HI; cnt_n = 8'd1; end
         WAIT_HI: if (!sync_q) state_n = LOW;
                  else if (done) state_n = HIGH;
                  else cnt_n = cnt + 8'd1;
         HIGH:    if (!sync_q) begin state_n = WAIT_LO; cnt_n = 8'd1; end
         WAIT_LO: if (sync_q) state_n = HIGH;
                  else if (done) state_n = LOW;
                  else cnt_n = cnt + 8'd1;
         default: state_n = LOW;
      endcase
   end
   // Outputs are decoded from the upcoming state so the registered o and the
   // pulses change on the same edge as the accepting state transition.
   always_comb begin
      o_n    = state_n == HIGH || state_n == WAIT_LO;
      rise_n = state == WAIT_HI && state_n == HIGH;
      fall_n = state == WAIT_LO && state_n == LOW;
   end
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: randomized and directed stimulus against a run-length reference model,
// with a scoreboard queue between the model and a negedge monitor.
module tb_debounce;
   localparam int SC = 4;
   logic clk = 1'b0, rst = 1'b1, in = 1'b0;
   logic o, rise, fall;
   int total = 0, bad = 0;
   logic [2:0] exp_q[$];
   debounce #(.STABLE_CYCLES(SC)) dut (.clk(clk), .rst(rst), .in(in), .o(o), .rise(rise), .fall(fall));
   always #5 clk = ~clk;
   // Reference model: the level flips once SC consecutive synchronized samples
   // (raw input two edges earlier) disagree with the current level.
   initial begin
      int hist[$];
      int lvl, run, smp;
      logic r, f;
      lvl = 0;
      run = 0;
      forever begin
         @(posedge clk);
         r = 1'b0;
         f = 1'b0;
         if (rst) begin
            hist.delete();
            lvl = 0;
            run = 0;
         end else begin
            hist.push_back(int'(in));
            smp = hist.size() >= 3 ? hist[hist.size() - 3] : 0;
            if (hist.size() > 8) void'(hist.pop_front());
            run = smp != lvl ? run + 1 : 0;
            if (run == SC) begin
               lvl = 1 - lvl;
               run = 0;
               r = lvl == 1;
               f = lvl == 0;
            end
         end
         exp_q.push_back({lvl[0], r, f});
      end
   end
   initial begin
      logic [2:0] e;
      forever begin
         @(negedge clk);
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got o/rise/fall=%b expected an entry", {o, rise, fall});
         end else begin
            e = exp_q.pop_front();
            if ({o, rise, fall} !== e) begin
               bad++;
               $display("FAIL o_rise_fall t=%0t got=%b exp=%b", $time, {o, rise, fall}, e);
            end
         end
      end
   end
   task automatic drive(input logic v, input int n);
      in = v;
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask
   initial begin
      drive(1'b0, 3);
      rst = 1'b0;
      drive(1'b0, 20);
      drive(1'b1, 10);
      drive(1'b0, 10);
      drive(1'b1, 10);
      drive(1'b0, 2);
      drive(1'b1, 10);
      for (int i = 0; i < 10; i++) drive(1'(i & 1), 1);
      drive(1'b1, 10);
      drive(1'b0, 10);
      drive(1'b1, 3);
      rst = 1'b1;
      drive(1'b1, 1);
      rst = 1'b0;
      drive(1'b1, 10);
      rst = 1'b1;
      drive(1'b1, 2);
      rst = 1'b0;
      drive(1'b1, 10);
      drive(1'b0, 3);
      rst = 1'b1;
      drive(1'b0, 1);
      rst = 1'b0;
      drive(1'b0, 8);
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 40) == 0) begin
            rst = 1'b1;
            drive(1'($urandom_range(0, 1)), 1);
            rst = 1'b0;
         end
         drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
      end
      drive(1'b0, 12);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive synchronized samples required to accept a new level; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in  input  1  raw, asynchronous, possibly bouncing level (e.g. switch feeding a/b of a downstream or_m).
REQ-005 o  output  1  debounced level, registered.
REQ-006 rise  output  1  one-cycle pulse on accepted 0->1 transition of o, registered.
REQ-007 fall  output  1  one-cycle pulse on accepted 1->0 transition of o, registered.

Function
REQ-008 in SHALL pass through a 2-flop synchronizer; sync_q (second flop output) is the only internal view of in.
REQ-009 Sample counter SHALL be 8 bits, unsigned, never wraps: cleared on every state change, saturates impossible by construction (max value STABLE_CYCLES-1).
REQ-010 FSM SHALL have exactly four states: LOW, WAIT_HI, HIGH, WAIT_LO.
REQ-011 LOW: o=0; sync_q==1 -> WAIT_HI with cnt=1; else stay, cnt=0.
REQ-012 WAIT_HI: o=0; sync_q==0 -> LOW, cnt=0, no pulse; sync_q==1 and cnt==STABLE_CYCLES-1 -> HIGH, cnt=0, rise=1 for the following cycle; else cnt+=1.
REQ-013 HIGH: o=1; sync_q==0 -> WAIT_LO with cnt=1; else stay, cnt=0.
REQ-014 WAIT_LO: o=1; sync_q==1 -> HIGH, cnt=0, no pulse; sync_q==0 and cnt==STABLE_CYCLES-1 -> LOW, cnt=0, fall=1 for the following cycle; else cnt+=1.
REQ-015 o SHALL change in the same cycle rise/fall is high; rise and fall SHALL never be high simultaneously and each SHALL be high for exactly one cycle per accepted transition.
REQ-016 Latency: for in stable from rising edge E0 onward, o changes immediately after edge E0+STABLE_CYCLES+1 (2 sync edges + STABLE_CYCLES samples); default = 6th edge.
REQ-017 Any opposite sample during WAIT_HI/WAIT_LO SHALL abort qualification; a glitch shorter than STABLE_CYCLES synchronized samples SHALL never change o.
REQ-018 Back-to-back accepted transitions SHALL be supported: minimum spacing between a rise and the next fall is STABLE_CYCLES cycles, no extra dead time.

Reset
REQ-019 While rst=1, asynchronously: both sync flops=0, state=LOW, cnt=0, o=0, rise=0, fall=0.
REQ-020 Reset asserted mid-WAIT_HI or mid-WAIT_LO SHALL discard qualification and emit no pulse; reset asserted in HIGH drops o to 0 with no fall pulse.
REQ-021 If in=1 at reset release, block SHALL qualify normally: o=1 and rise pulse after STABLE_CYCLES+2 edges, not immediately.

Verification (STABLE_CYCLES=4)
REQ-022 Reset, in=0 for 20 cycles -> o=0, rise=0, fall=0 throughout.
REQ-023 in 0->1 before edge E0, held -> o=1 and rise=1 immediately after edge E0+5, rise=0 after E0+6; no fall.
REQ-024 From HIGH, in low for 2 cycles then high -> o stays 1, no fall, state returns to HIGH.
REQ-025 Bounce: in toggles every cycle for 10 cycles then settles at 1 -> exactly one rise, o=1 within 6 edges of settling, no fall.
REQ-026 In WAIT_HI (in=1, 3 edges after change) assert rst for 1 cycle -> o=0, no rise; in still 1 -> rise occurs 6 edges after release.
REQ-027 Full cycle in=1 held 10, in=0 held 10 -> one rise then one fall, each one cycle wide, o mirrors in delayed by 6 edges.
